// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

   // Divider sequencer states
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } div_state_t;

   // Architectural register $0 never creates a dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Default divider latency in cycles
   localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// Divider sequencer: issues a one-cycle start pulse and holds busy for
// DIV_CYCLES cycles once a divide is accepted. A started divide always
// runs to completion unless the pipeline is reset.
module div_seq
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic div_accept,
   output logic div_start,
   output logic div_busy
);

   localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES);

   div_state_t state;
   logic [5:0] cnt;

   // State, down-counter and start pulse; the pulse is only ever high in the
   // first RUN cycle because it is cleared on every other edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         div_start <= 1'b0;
      end else begin
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (div_accept) begin
                  state     <= RUN;
                  cnt       <= CNT_INIT;
                  div_start <= 1'b1;
               end
            end
            RUN: begin
               if (cnt == 6'd1) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign div_busy = (state == RUN);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use and
// HI/LO-while-dividing stalls, taken-branch flushes, divider sequencing and
// a saturating stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_is_div,
   input  logic             id_reads_hilo,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             div_start,
   output logic             div_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic load_use;
   logic hilo_hz;
   logic stall;
   logic div_accept;
   logic seq_busy;

   // Busy is forced low while reset is held so nothing looks in-flight
   assign div_busy = seq_busy & rst;

   // Hazard detection; a taken branch kills the ID instruction, so it
   // neither stalls nor hands a divide to the sequencer.
   always_comb begin
      load_use   = ex_mem_read && (ex_rt != REG_ZERO) &&
                   ((id_uses_rs && (id_rs == ex_rt)) ||
                    (id_uses_rt && (id_rt == ex_rt)));
      hilo_hz    = div_busy && (id_reads_hilo || id_is_div);
      stall      = (load_use || hilo_hz) && !ex_branch_taken;
      div_accept = id_is_div && !stall && !ex_branch_taken;
   end

   // Pipeline register controls, all forced to their safe values in reset
   always_comb begin
      pc_write    = !stall || !rst;
      if_id_write = !stall || !rst;
      if_id_flush = ex_branch_taken || !rst;
      id_ex_flush = stall || ex_branch_taken || !rst;
   end

   // Saturating stall-cycle counter for performance measurement
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != CNT_MAX)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

   div_seq #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_seq (
      .clk        (clk),
      .rst        (rst),
      .div_accept (div_accept),
      .div_start  (div_start),
      .div_busy   (seq_busy)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with a 4-cycle divider and a
// 4-bit stall counter.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_is_div;
   logic       id_reads_hilo;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       ex_branch_taken;
   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       div_start;
   logic       div_busy;
   logic [3:0] stall_cycles;

   int n_checks = 0;
   int n_pass   = 0;

   pipe_hazard_ctrl #(
      .DIV_CYCLES (4),
      .CNT_W      (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .id_is_div       (id_is_div),
      .id_reads_hilo   (id_reads_hilo),
      .ex_mem_read     (ex_mem_read),
      .ex_rt           (ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .div_start       (div_start),
      .div_busy        (div_busy),
      .stall_cycles    (stall_cycles)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clear all ID/EX inputs to a harmless nop
   task automatic idle_inputs();
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_uses_rs      = 1'b0;
      id_uses_rt      = 1'b0;
      id_is_div       = 1'b0;
      id_reads_hilo   = 1'b0;
      ex_mem_read     = 1'b0;
      ex_rt           = 5'd0;
      ex_branch_taken = 1'b0;
   endtask

   // Advance to just after the next rising edge, where inputs are driven
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across two edges, then release it
   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      next_cycle();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
      #1;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL rst_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (if_id_write !== 1'b1) $display("[TB] FAIL rst_if_id_write got %b want 1", if_id_write); else n_pass++;
      n_checks++; if (if_id_flush !== 1'b1) $display("[TB] FAIL rst_if_id_flush got %b want 1", if_id_flush); else n_pass++;
      n_checks++; if (id_ex_flush !== 1'b1) $display("[TB] FAIL rst_id_ex_flush got %b want 1", id_ex_flush); else n_pass++;
      next_cycle();
      n_checks++; if (div_busy !== 1'b0) $display("[TB] FAIL rst_div_busy got %b want 0", div_busy); else n_pass++;
      n_checks++; if (div_start !== 1'b0) $display("[TB] FAIL rst_div_start got %b want 0", div_start); else n_pass++;
      n_checks++; if (stall_cycles !== 4'd0) $display("[TB] FAIL rst_stall_cycles got %0d want 0", stall_cycles); else n_pass++;
      rst = 1'b1;
      idle_inputs();
   endtask

   task automatic test_load_use();
      do_reset();
      next_cycle();
      // lw $8 in EX, add using $8 as rs in ID
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
      #1;
      n_checks++; if (pc_write !== 1'b0) $display("[TB] FAIL lu_pc_write got %b want 0", pc_write); else n_pass++;
      n_checks++; if (if_id_write !== 1'b0) $display("[TB] FAIL lu_if_id_write got %b want 0", if_id_write); else n_pass++;
      n_checks++; if (id_ex_flush !== 1'b1) $display("[TB] FAIL lu_id_ex_flush got %b want 1", id_ex_flush); else n_pass++;
      n_checks++; if (if_id_flush !== 1'b0) $display("[TB] FAIL lu_if_id_flush got %b want 0", if_id_flush); else n_pass++;
      next_cycle();
      // Load has moved to MEM; bubble is in EX
      idle_inputs();
      #1;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL lu_release_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (id_ex_flush !== 1'b0) $display("[TB] FAIL lu_release_id_ex_flush got %b want 0", id_ex_flush); else n_pass++;
      n_checks++; if (stall_cycles !== 4'd1) $display("[TB] FAIL lu_stall_cycles got %0d want 1", stall_cycles); else n_pass++;
      // rt match through id_uses_rt
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
      #1;
      n_checks++; if (pc_write !== 1'b0) $display("[TB] FAIL lu_rt_pc_write got %b want 0", pc_write); else n_pass++;
      next_cycle();
      // rs matches but the instruction does not read rs
      idle_inputs();
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b0;
      #1;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL lu_unused_rs_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (stall_cycles !== 4'd2) $display("[TB] FAIL lu_rt_stall_cycles got %0d want 2", stall_cycles); else n_pass++;
      next_cycle();
      idle_inputs();
      #1;
      n_checks++; if (stall_cycles !== 4'd2) $display("[TB] FAIL lu_unused_stall_cycles got %0d want 2", stall_cycles); else n_pass++;
   endtask

   task automatic test_load_zero();
      do_reset();
      next_cycle();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      #1;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL zero_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (id_ex_flush !== 1'b0) $display("[TB] FAIL zero_id_ex_flush got %b want 0", id_ex_flush); else n_pass++;
      next_cycle();
      idle_inputs();
      #1;
      n_checks++; if (stall_cycles !== 4'd0) $display("[TB] FAIL zero_stall_cycles got %0d want 0", stall_cycles); else n_pass++;
   endtask

   task automatic test_branch_precedence();
      do_reset();
      next_cycle();
      // Load-use plus a divide in ID, but a branch in EX resolves taken
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
      id_is_div = 1'b1; ex_branch_taken = 1'b1;
      #1;
      n_checks++; if (if_id_flush !== 1'b1) $display("[TB] FAIL br_if_id_flush got %b want 1", if_id_flush); else n_pass++;
      n_checks++; if (id_ex_flush !== 1'b1) $display("[TB] FAIL br_id_ex_flush got %b want 1", id_ex_flush); else n_pass++;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL br_pc_write got %b want 1", pc_write); else n_pass++;
      next_cycle();
      idle_inputs();
      #1;
      n_checks++; if (stall_cycles !== 4'd0) $display("[TB] FAIL br_stall_cycles got %0d want 0", stall_cycles); else n_pass++;
      n_checks++; if (div_busy !== 1'b0) $display("[TB] FAIL br_div_busy got %b want 0", div_busy); else n_pass++;
      n_checks++; if (div_start !== 1'b0) $display("[TB] FAIL br_div_start got %b want 0", div_start); else n_pass++;
   endtask

   task automatic test_divide();
      do_reset();
      next_cycle();
      // Cycle t: divide in ID is accepted
      id_is_div = 1'b1;
      #1;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL div_t_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (div_busy !== 1'b0) $display("[TB] FAIL div_t_div_busy got %b want 0", div_busy); else n_pass++;
      // Cycles t+1 .. t+4: mflo waits
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         idle_inputs();
         id_reads_hilo = 1'b1;
         #1;
         n_checks++; if (div_start !== (k == 1)) $display("[TB] FAIL div_start_t%0d got %b want %b", k, div_start, (k == 1)); else n_pass++;
         n_checks++; if (div_busy !== 1'b1) $display("[TB] FAIL div_busy_t%0d got %b want 1", k, div_busy); else n_pass++;
         n_checks++; if (pc_write !== 1'b0) $display("[TB] FAIL div_pc_write_t%0d got %b want 0", k, pc_write); else n_pass++;
      end
      // Cycle t+5: result valid, mflo advances
      next_cycle();
      #1;
      n_checks++; if (div_busy !== 1'b0) $display("[TB] FAIL div_t5_div_busy got %b want 0", div_busy); else n_pass++;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL div_t5_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (stall_cycles !== 4'd4) $display("[TB] FAIL div_stall_cycles got %0d want 4", stall_cycles); else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      do_reset();
      next_cycle();
      // Divide held in ID: first accepted at t, second waits t+1..t+4
      id_is_div = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         #1;
         n_checks++; if (pc_write !== 1'b0) $display("[TB] FAIL b2b_pc_write_t%0d got %b want 0", k, pc_write); else n_pass++;
      end
      next_cycle();
      #1;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL b2b_accept_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (div_busy !== 1'b0) $display("[TB] FAIL b2b_accept_div_busy got %b want 0", div_busy); else n_pass++;
      next_cycle();
      idle_inputs();
      #1;
      n_checks++; if (div_start !== 1'b1) $display("[TB] FAIL b2b_second_start got %b want 1", div_start); else n_pass++;
      n_checks++; if (div_busy !== 1'b1) $display("[TB] FAIL b2b_second_busy got %b want 1", div_busy); else n_pass++;
      n_checks++; if (stall_cycles !== 4'd4) $display("[TB] FAIL b2b_stall_cycles got %0d want 4", stall_cycles); else n_pass++;
      repeat (5) next_cycle();
   endtask

   task automatic test_reset_mid_divide();
      do_reset();
      next_cycle();
      id_is_div = 1'b1;
      next_cycle();
      // t+1
      idle_inputs();
      id_reads_hilo = 1'b1;
      next_cycle();
      // t+2: reset asserted while mflo waits
      rst = 1'b0;
      #1;
      n_checks++; if (div_busy !== 1'b0) $display("[TB] FAIL mid_rst_div_busy got %b want 0", div_busy); else n_pass++;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL mid_rst_pc_write got %b want 1", pc_write); else n_pass++;
      next_cycle();
      // t+3: out of reset, the divide is gone
      rst = 1'b1;
      #1;
      n_checks++; if (div_busy !== 1'b0) $display("[TB] FAIL mid_post_div_busy got %b want 0", div_busy); else n_pass++;
      n_checks++; if (pc_write !== 1'b1) $display("[TB] FAIL mid_post_pc_write got %b want 1", pc_write); else n_pass++;
      n_checks++; if (id_ex_flush !== 1'b0) $display("[TB] FAIL mid_post_id_ex_flush got %b want 0", id_ex_flush); else n_pass++;
      n_checks++; if (stall_cycles !== 4'd0) $display("[TB] FAIL mid_post_stall_cycles got %0d want 0", stall_cycles); else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      // Divides held in ID: accept every 5th cycle, stall the other 4
      for (int i = 0; i < 30; i++) begin
         next_cycle();
         id_is_div = 1'b1;
         #1;
         if (i == 10) begin
            n_checks++; if (stall_cycles !== 4'd8) $display("[TB] FAIL sat_mid got %0d want 8", stall_cycles); else n_pass++;
         end
         if (i == 20) begin
            n_checks++; if (stall_cycles !== 4'd15) $display("[TB] FAIL sat_reach got %0d want 15", stall_cycles); else n_pass++;
         end
      end
      next_cycle();
      idle_inputs();
      #1;
      n_checks++; if (stall_cycles !== 4'd15) $display("[TB] FAIL sat_hold got %0d want 15", stall_cycles); else n_pass++;
   endtask

   // Run every scenario in order and report
   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_load_use();
      test_load_zero();
      test_branch_precedence();
      test_divide();
      test_back_to_back();
      test_reset_mid_divide();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, IF_ID and ID_EXE registers, and sequences a multi-cycle divider that hangs off the EX stage. It detects load-use hazards and HI/LO-use-while-dividing hazards, and inserts bubbles into ID_EXE. It also flushes wrong-path instructions on a taken branch resolved in EX, and counts stall cycles for performance measurement.

## Interface
- DIV_CYCLES, 32: divider busy duration in cycles; legal range 2..63.
- CNT_W, 16: width of the saturating stall-cycle counter.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  the ID instruction reads rs.
- id_uses_rt  in  1  the ID instruction reads rt.
- id_is_div  in  1  the ID instruction is div/divu.
- id_reads_hilo  in  1  the ID instruction is mfhi/mflo.
- ex_mem_read  in  1  Mem_Read of the instruction currently in EX (ID_EXE output).
- ex_rt  in  5  destination rt of the instruction in EX (ID_EXE ir_2016 output).
- ex_branch_taken  in  1  a branch or bne in EX resolved taken this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF_ID load enable.
- if_id_flush  out  1  IF_ID loads a nop this cycle.
- id_ex_flush  out  1  ID_EXE loads all-zero controls (bubble) this cycle.
- div_start  out  1  one-cycle pulse to the divider.
- div_busy  out  1  divider result is not yet valid.
- stall_cycles  out  CNT_W  saturating count of stall cycles since reset.

## Operation
- load_use = ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- hilo_hz = div_busy & (id_reads_hilo | id_is_div). A second divide waits for the first to finish.
- stall = (load_use | hilo_hz) & ~ex_branch_taken.
- Combinational outputs:
  - pc_write = if_id_write = ~stall.
  - if_id_flush = ex_branch_taken.
  - id_ex_flush = stall | ex_branch_taken.
- Priority: branch flush > load-use > HI/LO. When a branch is taken, the ID instruction is killed, so no stall is raised for it.
- div_accept = id_is_div & ~stall & ~ex_branch_taken. The divide leaves ID this cycle.
- Divider FSM:
  - States: IDLE, RUN.
  - IDLE -> RUN on div_accept. Next cycle: cnt = DIV_CYCLES, div_start = 1.
  - RUN: div_start = 0 after the first cycle. cnt decrements each cycle.
  - RUN -> IDLE when cnt == 1 at the edge; cnt becomes 0.
  - div_busy = (state == RUN).
- Once started, a divide is never cancelled. A later branch cannot flush it because it is older than any branch that follows it.
- stall_cycles increments on every clock edge where stall = 1 and rst = 1. It holds at 2^CNT_W − 1 once it saturates.

## Timing
- Reset: when rst = 0 at a rising edge, the block enters IDLE with cnt = 0, div_start = 0 and stall_cycles = 0.
- While rst = 0 the combinational outputs are forced: pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_flush = 1, div_busy = 0.
- A reset mid-divide abandons the divide immediately.
- Load-use: exactly one stall cycle. On the next cycle the load has moved to MEM, so load_use clears.
- Divide accepted at cycle t:
  - div_start = 1 at t+1.
  - div_busy = 1 for cycles t+1 .. t+DIV_CYCLES.
  - A dependent mfhi/mflo or div in ID stalls through t+DIV_CYCLES and advances at t+DIV_CYCLES+1.
- Simultaneous load_use and hilo_hz count as one stall cycle, not two.
- ex_branch_taken during a stall: the flush wins for that cycle and the stall is not counted.
- No latency is added on the non-hazard path. All control outputs are valid in the same cycle as their inputs.

## Structure
- Shared package pipe_pkg:
  - FSM state enum (IDLE, RUN).
  - Register-zero constant REG_ZERO = 5'd0.
  - Default DIV_CYCLES.
- Optional sub-module div_seq holds the FSM, the down-counter and div_start/div_busy.
- Hazard equations and the stall counter stay in the top module.

## Test plan
- Load-use: lw $8 in EX (ex_mem_read = 1, ex_rt = 8); add in ID with id_rs = 8, id_uses_rs = 1.
  - Required: pc_write = 0 and id_ex_flush = 1 for exactly one cycle; stall_cycles increments by 1.
- Load to $0: ex_rt = 0, id_rs = 0.
  - Required: no stall; pc_write = 1.
- Branch precedence: ex_branch_taken = 1 while a load-use condition is also present.
  - Required: if_id_flush = id_ex_flush = 1, pc_write = 1, stall_cycles unchanged.
- Divide then mflo with DIV_CYCLES = 4: div accepted at t, mflo in ID from t+1.
  - Required: div_start pulse at t+1, div_busy high t+1..t+4, pc_write = 0 t+1..t+4, pc_write = 1 at t+5, stall_cycles += 4.
- Reset mid-divide: rst = 0 at t+2 of a divide.
  - Required: div_busy = 0 and cnt = 0 after that edge; a mflo in ID is not stalled once rst = 1.
- Saturation with CNT_W = 4: hold a HI/LO stall for 20 cycles.
  - Required: stall_cycles stops at 15.
